mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised N-channel arbiter that merges several req/rdy memory requesters onto one downstream memory port.
//  Typical requesters are core icache/dcache ports, or ports from several cores.
//  Sits between the cpu/pipeline cache ports and the single memory bus.
//  Round-robin grant, one outstanding transaction, registered downstream and response signals.
// PARAMETERS
//  NUM_CH  2   number of requester channels (>=2)
//  ADDR_W  32  address width
//  DATA_W  32  read/write data width
//  CH_W    $clog2(NUM_CH) (localparam) grant index width
// PORTS
//  clock      in   1             single clock, all state on rising edge
//  reset      in   1             asynchronous, active-low reset (reset==0 clears all state)
//  ch_req     in   NUM_CH        per-channel request, held until that channel's ch_rdy
//  ch_wr      in   NUM_CH        per-channel write (1) / read (0)
//  ch_addr    in   NUM_CH*ADDR_W channel i at [i*ADDR_W +: ADDR_W]
//  ch_wdata   in   NUM_CH*DATA_W channel i at [i*DATA_W +: DATA_W]
//  ch_rdata   out  DATA_W        shared read data, valid while any ch_rdy bit is high
//  ch_rdy     out  NUM_CH        one-cycle completion pulse, one-hot or zero
//  mem_addr   out  ADDR_W        downstream address
//  mem_wdata  out  DATA_W        downstream write data
//  mem_req    out  1             downstream request
//  mem_wr     out  1             downstream write
//  mem_rdata  in   DATA_W        downstream read data, valid with mem_rdy
//  mem_rdy    in   1             downstream completion, sampled only in BUSY
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state=IDLE; mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, ch_rdy=0, ch_rdata=0.
//   - last_grant=NUM_CH-1, so channel 0 has top priority after reset.
//  FSM states: IDLE, BUSY, RESP.
//   - IDLE: if any ch_req, pick g = first set bit scanning (last_grant+1) mod NUM_CH upward with wrap.
//     Register addr/wr/wdata of g into the mem_* outputs, set mem_req=1, last_grant=g, go BUSY.
//     With no ch_req, stay IDLE.
//   - BUSY: mem_req held, mem_* stable.
//     On mem_rdy=1: mem_req=0, ch_rdata<=mem_rdata, ch_rdy<=(1<<g), go RESP.
//     mem_rdy=1 in the first BUSY cycle is legal and accepted.
//   - RESP: ch_rdy high exactly this cycle; next edge ch_rdy=0, go IDLE.
//  Timing:
//   - Latency: ch_req sampled at edge E -> mem_req high from E+1.
//   - mem_rdy seen at edge F -> ch_rdy high for cycle after F.
//   - Minimum request-to-rdy: 2 cycles. Grant spacing: >=3 cycles (IDLE, BUSY, RESP).
//  Handshake rules:
//   - Requester keeps req/wr/addr/wdata stable until it samples its ch_rdy.
//   - Requester drops or renews req registered on that edge, so IDLE never sees a stale request.
//   - Channel inputs are sampled only in IDLE. Changes during BUSY/RESP do not affect the active transaction.
//  Boundary conditions:
//   - Granted channel drops ch_req mid-transaction: transaction still completes and ch_rdy still pulses.
//   - mem_rdy in IDLE/RESP: ignored.
//   - All channels requesting: strict rotation, each channel granted once per NUM_CH grants.
//   - Same channel re-requests back-to-back with others idle: re-granted (scan wraps to itself).
//   - Reset mid-BUSY: outputs clear immediately, transaction dropped, no ch_rdy.
//     Downstream must tolerate an abandoned req.
//   - Writes: ch_rdata still loaded from mem_rdata (don't-care to requester).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN:
//   - defined: fixed priority, lowest-index requesting channel always wins; last_grant unused.
//   - undefined (default): round-robin as above.
//   - FSM, latency and handshake are identical in both modes.
// TESTING
//  1. Reset: hold reset=0, then release -> all outputs 0, state IDLE; ch_req=0 for 10 cycles -> mem_req stays 0.
//  2. Single read, NUM_CH=2: ch_req=01, ch_addr[0]=0x100, mem_rdy=1 with mem_rdata=0xDEADBEEF
//     in the 3rd cycle after mem_req -> mem_addr=0x100, mem_wr=0; ch_rdy=01 one cycle, ch_rdata=0xDEADBEEF.
//  3. Contention, NUM_CH=4: all ch_req held, each transaction renews req -> grant order 0,1,2,3,0,1.
//     With ARB_FIXED_PRIO_EN: grant order 0,0,0,...
//  4. Write: ch_req=10, ch_wr=10, ch_addr[1]=0x2000, ch_wdata[1]=0x12345678
//     -> mem_req=1, mem_wr=1, mem_addr=0x2000, mem_wdata=0x12345678 until mem_rdy; ch_rdy=10 one cycle.
//  5. Zero-wait memory: mem_rdy tied 1 -> ch_rdy exactly 2 cycles after ch_req sampled; no double grant.
//  6. Reset mid-BUSY: drive reset=0 while mem_req=1 -> mem_req=0 asynchronously, no ch_rdy.
//     After release, channel 0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-channel req/rdy arbiter merging requesters onto one memory port, one transaction in flight.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default build is round-robin.
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rdy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rdy
);

  localparam int CH_W = $clog2(NUM_CH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  // Channel of the current/most recent grant; doubles as the round-robin pointer.
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] pick;
  logic            pick_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    pick       = '0;
    pick_valid = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        pick       = CH_W'(i);
        pick_valid = 1'b1;
      end
    end
`else
    // Scan downward so the smallest offset from last_grant is the final (winning) assignment.
    for (int k = NUM_CH; k >= 1; k--) begin
      if (ch_req[(int'(last_grant) + k) % NUM_CH]) begin
        pick       = CH_W'((int'(last_grant) + k) % NUM_CH);
        pick_valid = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      last_grant <= CH_W'(NUM_CH - 1);
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ch_rdy     <= '0;
      ch_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mem_addr   <= ch_addr[pick*ADDR_W +: ADDR_W];
            mem_wdata  <= ch_wdata[pick*DATA_W +: DATA_W];
            mem_wr     <= ch_wr[pick];
            mem_req    <= 1'b1;
            last_grant <= pick;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Read data is captured for writes too; requesters ignore it then.
          if (mem_rdy) begin
            mem_req  <= 1'b0;
            ch_rdata <= mem_rdata;
            ch_rdy   <= NUM_CH'(1) << last_grant;
            state    <= RESP;
          end
        end
        RESP: begin
          ch_rdy <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester agents and a memory responder
// driven against a transaction-level reference of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_CH-1:0]        ch_req, ch_wr, ch_rdy;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_req, mem_wr, mem_rdy;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_wr    (ch_wr),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata),
    .ch_rdy   (ch_rdy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_rdy  (mem_rdy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester agents
  bit                a_pend [NUM_CH];
  bit                a_wait [NUM_CH];
  logic              a_wr   [NUM_CH];
  logic [ADDR_W-1:0] a_addr [NUM_CH];
  logic [DATA_W-1:0] a_wdata[NUM_CH];

  // Stimulus knobs
  int          req_prob, rdy_prob, spur_prob, drop_prob, mem_delay;
  bit          fix_data;
  logic [DATA_W-1:0] fixed_rdata;
  int          busy_cnt;

  // Reference model: who owns the port, whether a response pulse is showing, last winner
  int                m_owner, m_last;
  bit                m_resp;
  logic              exp_req, exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_rdata;
  logic [NUM_CH-1:0] exp_rdy;

  // Observations
  int                rdy_log[$];
  logic [DATA_W-1:0] last_rdata;
  logic              prev_mem_req, g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  function automatic int arb_pick(input logic [NUM_CH-1:0] req, input int last);
`ifdef ARB_FIXED_PRIO_EN
    if (last >= NUM_CH) return -1;
    for (int i = 0; i < NUM_CH; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= NUM_CH; k++) if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
`endif
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_req[i]                      = a_pend[i];
      ch_wr[i]                       = a_wr[i];
      ch_addr[i*ADDR_W +: ADDR_W]    = a_addr[i];
      ch_wdata[i*DATA_W +: DATA_W]   = a_wdata[i];
    end
  endtask

  task automatic load(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata);
    a_pend[ch]  = 1'b1;
    a_wr[ch]    = wr;
    a_addr[ch]  = addr;
    a_wdata[ch] = wdata;
  endtask

  task automatic set_knobs(input int rq, input int rd, input int sp, input int dr, input int dly);
    req_prob  = rq;
    rdy_prob  = rd;
    spur_prob = sp;
    drop_prob = dr;
    mem_delay = dly;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      a_pend[i] = 1'b0; a_wait[i] = 1'b0; a_wr[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
    end
    drive_inputs();
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clock);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_ch_rdy", ch_rdy, '0);
    check("rst_ch_rdata", ch_rdata, '0);
    m_owner = -1; m_resp = 1'b0; m_last = NUM_CH - 1;
    exp_req = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_rdy = '0;
    busy_cnt = 0; prev_mem_req = 1'b0;
    fix_data = 1'b0;
    rdy_log.delete();
    reset = 1'b1;
  endtask

  // One clock: compare DUT against the model, react as requesters/memory, then predict the next edge.
  task automatic step();
    int g;
    @(negedge clock);
    check("mem_req", mem_req, exp_req);
    check("mem_wr", mem_wr, exp_wr);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_wdata", mem_wdata, exp_wdata);
    check("ch_rdy", ch_rdy, exp_rdy);
    check("ch_rdata", ch_rdata, exp_rdata);

    if (mem_req && !prev_mem_req) begin
      g_addr = mem_addr; g_wr = mem_wr; g_wdata = mem_wdata;
    end
    prev_mem_req = mem_req;

    if (ch_rdy != '0) begin
      g = -1;
      for (int i = 0; i < NUM_CH; i++) if (ch_rdy[i]) g = i;
      rdy_log.push_back(g);
      last_rdata = ch_rdata;
      for (int i = 0; i < NUM_CH; i++) if (ch_rdy[i]) begin a_pend[i] = 1'b0; a_wait[i] = 1'b0; end
    end
    busy_cnt = mem_req ? busy_cnt + 1 : 0;

    if (m_owner >= 0 && a_pend[m_owner] && $urandom_range(99) < drop_prob) begin
      a_pend[m_owner] = 1'b0;
      a_wait[m_owner] = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!a_pend[i] && !a_wait[i] && $urandom_range(99) < req_prob)
        load(i, 1'($urandom), $urandom, $urandom);
    end
    drive_inputs();

    mem_rdata = fix_data ? fixed_rdata : DATA_W'($urandom);
    if (mem_req) mem_rdy = (mem_delay > 0) ? (busy_cnt == mem_delay) : ($urandom_range(99) < rdy_prob);
    else         mem_rdy = ($urandom_range(99) < spur_prob);

    if (m_resp) begin
      exp_rdy = '0;
      m_resp  = 1'b0;
    end else if (m_owner >= 0) begin
      if (mem_rdy) begin
        exp_req          = 1'b0;
        exp_rdy          = '0;
        exp_rdy[m_owner] = 1'b1;
        exp_rdata        = mem_rdata;
        m_resp           = 1'b1;
        m_owner          = -1;
      end
    end else begin
      g = arb_pick(ch_req, m_last);
      if (g >= 0) begin
        exp_req   = 1'b1;
        exp_wr    = a_wr[g];
        exp_addr  = a_addr[g];
        exp_wdata = a_wdata[g];
        m_owner   = g;
        m_last    = g;
      end
    end
  endtask

  int k;
`ifdef ARB_FIXED_PRIO_EN
  int exp_order[6] = '{0, 0, 0, 0, 0, 0};
`else
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
`endif

  initial begin
    mem_rdy = 1'b0;
    mem_rdata = '0;
    fixed_rdata = '0;
    set_knobs(0, 0, 0, 0, 0);

    // Reset and idle
    do_reset();
    repeat (10) step();
    check("t1_idle_mem_req", mem_req, 1'b0);

    // Single read, memory answers in the 3rd cycle of mem_req
    do_reset();
    set_knobs(0, 0, 0, 0, 3);
    fix_data = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    load(0, 1'b0, 32'h100, 32'h0);
    repeat (8) step();
    check("t2_mem_addr", g_addr, 32'h100);
    check("t2_mem_wr", g_wr, 1'b0);
    check("t2_rdy_count", rdy_log.size(), 1);
    check("t2_rdy_ch", (rdy_log.size() > 0) ? rdy_log[0] : -1, 0);
    check("t2_rdata", last_rdata, 32'hDEAD_BEEF);

    // Single write on channel 1
    do_reset();
    set_knobs(0, 0, 0, 0, 2);
    load(1, 1'b1, 32'h2000, 32'h1234_5678);
    repeat (8) step();
    check("t4_mem_addr", g_addr, 32'h2000);
    check("t4_mem_wr", g_wr, 1'b1);
    check("t4_mem_wdata", g_wdata, 32'h1234_5678);
    check("t4_rdy_count", rdy_log.size(), 1);
    check("t4_rdy_ch", (rdy_log.size() > 0) ? rdy_log[0] : -1, 1);

    // Full contention, every requester renews immediately
    do_reset();
    set_knobs(100, 50, 0, 0, 0);
    k = 0;
    while (rdy_log.size() < 6 && k < 300) begin step(); k++; end
    check("t3_completions", (rdy_log.size() >= 6), 1'b1);
    if (rdy_log.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("t3_order%0d", i), rdy_log[i], exp_order[i]);

    // Zero-wait memory with mem_rdy tied high
    do_reset();
    set_knobs(0, 0, 100, 0, 1);
    load(2, 1'b0, 32'h40, 32'h0);
    step();
    k = 0;
    while (rdy_log.size() == 0 && k < 20) begin step(); k++; end
    check("t5_latency", k, 2);
    repeat (10) step();
    check("t5_single_rdy", rdy_log.size(), 1);

    // Reset while BUSY, then channel 0 must win first
    do_reset();
    set_knobs(0, 0, 0, 0, 0);
    load(1, 1'b0, 32'h80, 32'h0);
    k = 0;
    while (!(mem_req && m_owner >= 0) && k < 20) begin step(); k++; end
    check("t6_busy_reached", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_mem_req", mem_req, 1'b0);
    check("t6_async_ch_rdy", ch_rdy, '0);
    check("t6_async_mem_addr", mem_addr, '0);
    do_reset();
    set_knobs(0, 50, 0, 0, 0);
    for (int i = 0; i < NUM_CH; i++) load(i, 1'b0, ADDR_W'(32'h1000 + i), '0);
    k = 0;
    while (rdy_log.size() == 0 && k < 100) begin step(); k++; end
    check("t6_first_grant", (rdy_log.size() > 0) ? rdy_log[0] : -1, 0);

    // Random traffic with drops, spurious mem_rdy and variable latency
    do_reset();
    set_knobs(30, 40, 20, 10, 0);
    repeat (2000) step();
    check("rand_progress", (rdy_log.size() > 50), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
